reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb_pkg.sv | 22 ++
 rtl/reg_file_sb_if.sv | 28 ++
 rtl/reg_file_sb_scoreboard.sv | 72 +++++++
 rtl/reg_file_sb.sv | 76 +++++++
 tb/tb_reg_file_sb.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned DEF_NRD   = 2;
    localparam int unsigned REG_ZERO  = 0;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned res;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file; master = pipeline, slave = register file.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = clog2(DEF_DEPTH),
    parameter int unsigned NRD   = DEF_NRD
);
    logic [NRD*AW-1:0]    Read_reg;
    logic [NRD*WIDTH-1:0] Read_data;
    logic [NRD-1:0]       Read_busy;
    logic                 Reg_write;
    logic [AW-1:0]        Write_reg;
    logic [WIDTH-1:0]     Write_data;
    logic                 Issue_valid;
    logic [AW-1:0]        Issue_reg;
    logic [AW:0]          Busy_count;

    modport master (
        output Read_reg, Reg_write, Write_reg, Write_data, Issue_valid, Issue_reg,
        input  Read_data, Read_busy, Busy_count
    );

    modport slave (
        input  Read_reg, Reg_write, Write_reg, Write_data, Issue_valid, Issue_reg,
        output Read_data, Read_busy, Busy_count
    );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: busy vector, set-over-clear priority, busy count and per-port busy lookup.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = clog2(DEPTH),
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_clr_en,
    input  logic [AW-1:0]     i_clr_reg,
    input  logic              i_set_en,
    input  logic [AW-1:0]     i_set_reg,
    input  logic [NRD*AW-1:0] i_rd_reg,
    output logic [NRD-1:0]    o_rd_busy,
    output logic [AW:0]       o_busy_count
);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_clr;
    logic [DEPTH-1:0] w_busy_next;
    logic [CW-1:0]    r_count;
    logic [NRD-1:0]   r_rd_busy;
    logic [NRD-1:0]   w_rd_busy;
    logic             w_set_en;
    logic             w_inc;
    logic             w_dec;

    assign w_set_en = i_set_en && !(ZERO_REG && (i_set_reg == AW'(REG_ZERO)));

    // Clear is applied first so that a same-cycle set on the same register wins.
    always_comb begin
        w_busy_clr = r_busy;
        if (i_clr_en) begin
            w_busy_clr[i_clr_reg] = 1'b0;
        end
        w_busy_next = w_busy_clr;
        if (w_set_en) begin
            w_busy_next[i_set_reg] = 1'b1;
        end
    end

    assign w_dec = i_clr_en && r_busy[i_clr_reg];
    assign w_inc = w_set_en && !w_busy_clr[i_set_reg];

    // Readers see the post-clear, pre-set view, matching the bypassed data.
    always_comb begin
        w_rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            w_rd_busy[i] = w_busy_clr[i_rd_reg[i*AW +: AW]];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_busy    <= '0;
            r_count   <= '0;
            r_rd_busy <= '0;
        end else begin
            r_busy    <= w_busy_next;
            r_count   <= r_count + CW'(w_inc) - CW'(w_dec);
            r_rd_busy <= w_rd_busy;
        end
    end

    assign o_rd_busy    = r_rd_busy;
    assign o_busy_count = r_count;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with write-to-read bypass, registered reads and a RAW-hazard scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic          Clk,
    input  logic          Rst,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;

    // Writes to the hardwired zero register are dropped here, so they never bypass either.
    assign w_wr_en = bus.Reg_write && !(ZERO_REG && (bus.Write_reg == AW'(REG_ZERO)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                r_mem[AW'(r)] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.Write_reg] <= bus.Write_data;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]    w_idx;
        logic [WIDTH-1:0] w_sel;
        logic [WIDTH-1:0] r_data;

        assign w_idx = bus.Read_reg[g*AW +: AW];

        always_comb begin
            w_sel = r_mem[w_idx];
            if (ZERO_REG && (w_idx == AW'(REG_ZERO))) begin
                w_sel = '0;
            end else if (w_wr_en && (bus.Write_reg == w_idx)) begin
                w_sel = bus.Write_data;
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                r_data <= '0;
            end else begin
                r_data <= w_sel;
            end
        end

        assign bus.Read_data[g*WIDTH +: WIDTH] = r_data;
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_clr_en     (bus.Reg_write),
        .i_clr_reg    (bus.Write_reg),
        .i_set_en     (bus.Issue_valid),
        .i_set_reg    (bus.Issue_reg),
        .i_rd_reg     (bus.Read_reg),
        .o_rd_busy    (bus.Read_busy),
        .o_busy_count (bus.Busy_count)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed, table-driven bench for reg_file_sb: default config (A) and NRD=3/DEPTH=16/WIDTH=16 (B) side by side.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int unsigned AW_A = clog2(32);
    localparam int unsigned AW_B = clog2(16);

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  ireg;
        logic [4:0]  rr0;
        logic [4:0]  rr1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic [5:0]  ecnt;
        logic        a_only;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    reg_file_sb_if #(.WIDTH(32), .AW(AW_A), .NRD(2)) bus_a ();
    reg_file_sb_if #(.WIDTH(16), .AW(AW_B), .NRD(3)) bus_b ();

    reg_file_sb #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1'b1)) dut_a (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_a)
    );

    reg_file_sb #(.WIDTH(16), .DEPTH(16), .NRD(3), .ZERO_REG(1'b1)) dut_b (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_b)
    );

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wreg,
                                input logic [31:0] wdata, input logic iv, input logic [4:0] ireg,
                                input logic [4:0] rr0, input logic [4:0] rr1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input logic [1:0] eb, input logic [5:0] ecnt, input logic a_only);
        vec_t v;
        v.rst = rst; v.we = we; v.wreg = wreg; v.wdata = wdata; v.iv = iv; v.ireg = ireg;
        v.rr0 = rr0; v.rr1 = rr1; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ecnt = ecnt;
        v.a_only = a_only;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // B reads {rr0, rr1, rr0} on ports 0..2; its indices and data are the low bits of the vector fields.
    task automatic drive(input vec_t v);
        Rst               = v.rst;
        bus_a.Reg_write   = v.we;
        bus_a.Write_reg   = v.wreg;
        bus_a.Write_data  = v.wdata;
        bus_a.Issue_valid = v.iv;
        bus_a.Issue_reg   = v.ireg;
        bus_a.Read_reg    = {v.rr1, v.rr0};
        bus_b.Reg_write   = v.we;
        bus_b.Write_reg   = v.wreg[3:0];
        bus_b.Write_data  = v.wdata[15:0];
        bus_b.Issue_valid = v.iv;
        bus_b.Issue_reg   = v.ireg[3:0];
        bus_b.Read_reg    = {v.rr0[3:0], v.rr1[3:0], v.rr0[3:0]};
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        @(posedge Clk);
        #1;
        chk({tag, ".a.d0"},   32'(bus_a.Read_data[31:0]),  v.ed0);
        chk({tag, ".a.d1"},   32'(bus_a.Read_data[63:32]), v.ed1);
        chk({tag, ".a.busy"}, 32'(bus_a.Read_busy),        32'(v.eb));
        chk({tag, ".a.cnt"},  32'(bus_a.Busy_count),       32'(v.ecnt));
        if (!v.a_only) begin
            chk({tag, ".b.d0"},   32'(bus_b.Read_data[15:0]),  32'(v.ed0[15:0]));
            chk({tag, ".b.d1"},   32'(bus_b.Read_data[31:16]), 32'(v.ed1[15:0]));
            chk({tag, ".b.d2"},   32'(bus_b.Read_data[47:32]), 32'(v.ed0[15:0]));
            chk({tag, ".b.busy"}, 32'(bus_b.Read_busy),        32'({v.eb[0], v.eb[1], v.eb[0]}));
            chk({tag, ".b.cnt"},  32'(bus_b.Busy_count),       32'(v.ecnt[4:0]));
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        @(negedge Clk);
        drive(v);
        check_vec(tag, v);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t hs[$];

        drive(mk(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        //           rst we wreg wdata         iv ireg rr0 rr1 ed0           ed1           eb     cnt
        tbl.push_back(mk(1, 0,  0, 32'h0,        0,  0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 12, 32'h0000C0A0, 0,  0, 12,  0, 32'h0000C0A0, 32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(1, 0,  0, 32'h0,        0,  0, 12,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0, 12,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 12, 32'h0000C0A0, 0,  0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0, 12,  0, 32'h0000C0A0, 32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 1,  2, 32'h0000000A, 0,  0,  2,  2, 32'h0000000A, 32'h0000000A, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0,  2, 12, 32'h0000000A, 32'h0000C0A0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1,  0, 32'hFFFFFFFF, 1,  0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0,  0,  2, 32'h0,        32'h0000000A, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        1,  9,  9,  2, 32'h0,        32'h0000000A, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0,  9,  9, 32'h0,        32'h0,        2'b11, 1, 0));
        tbl.push_back(mk(0, 1,  9, 32'h00A5D604, 0,  0,  9, 12, 32'h00A5D604, 32'h0000C0A0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        1,  5,  5,  9, 32'h0,        32'h00A5D604, 2'b00, 1, 0));
        tbl.push_back(mk(0, 1,  5, 32'h12345678, 1,  5,  5,  5, 32'h12345678, 32'h12345678, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0,  5,  0, 32'h12345678, 32'h0,        2'b01, 1, 0));
        tbl.push_back(mk(0, 1,  2, 32'h0BAD0BAD, 0,  0,  2,  5, 32'h0BAD0BAD, 32'h12345678, 2'b10, 1, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        1,  5,  5,  2, 32'h12345678, 32'h0BAD0BAD, 2'b01, 1, 0));
        tbl.push_back(mk(0, 1,  5, 32'h5555AAAA, 1,  3,  3,  5, 32'h0,        32'h5555AAAA, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        1,  7,  3,  7, 32'h0,        32'h0,        2'b01, 2, 0));
        tbl.push_back(mk(1, 1,  7, 32'h0000DEAD, 1,  8,  2,  0, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0,  7,  2, 32'h0,        32'h0,        2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 15, 32'h0000FFFF, 1, 15, 15, 15, 32'h0000FFFF, 32'h0000FFFF, 2'b00, 1, 0));
        tbl.push_back(mk(0, 0,  0, 32'h0,        0,  0, 15,  1, 32'h0000FFFF, 32'h0,        2'b01, 1, 0));

        foreach (tbl[k]) begin
            run_vec($sformatf("v%0d", k), tbl[k]);
        end

        // Registers 16 and 31 only exist in config A.
        hs.push_back(mk(1, 0,  0, 32'h0,        0,  0,  0,  0, 32'h0,        32'h0,        2'b00, 0, 1));
        hs.push_back(mk(0, 0,  0, 32'h0,        1, 16, 16, 16, 32'h0,        32'h0,        2'b00, 1, 1));
        hs.push_back(mk(0, 0,  0, 32'h0,        0,  0, 16, 16, 32'h0,        32'h0,        2'b11, 1, 1));
        hs.push_back(mk(0, 1, 16, 32'h00A5D604, 0,  0, 16, 16, 32'h00A5D604, 32'h00A5D604, 2'b00, 0, 1));
        hs.push_back(mk(0, 1, 31, 32'h80000001, 1, 31, 31, 16, 32'h80000001, 32'h00A5D604, 2'b00, 1, 1));
        hs.push_back(mk(0, 0,  0, 32'h0,        0,  0, 31, 16, 32'h80000001, 32'h00A5D604, 2'b01, 1, 1));

        for (int k = 0; k < 3; k++) begin
            run_vec($sformatf("h%0d", k), hs[k]);
        end

        // Outputs are registered: before the edge the writeback is still invisible.
        @(negedge Clk);
        drive(hs[3]);
        #2;
        chk("h3.pre.a.busy", 32'(bus_a.Read_busy),        32'h3);
        chk("h3.pre.a.d0",   32'(bus_a.Read_data[31:0]),  32'h0);
        chk("h3.pre.a.cnt",  32'(bus_a.Busy_count),       32'h1);
        check_vec("h3", hs[3]);

        for (int k = 4; k < 6; k++) begin
            run_vec($sformatf("h%0d", k), hs[k]);
        end

        @(negedge Clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
